mux_scan_serializer: RTL

Sequential driver and consumer for the 16-to-1 select tree. It latches a 16-bit word onto the tree's data inputs and steps the 4-bit select from 0 to 15. At each step it samples the single-bit tree output, which produces a serial LSB-first bit stream plus a reassembled 16-bit capture. It sits directly around the mux: it feeds the tree's `A`/`S` inputs and consumes its `w` output.

---
 rtl/mux_scan_serializer.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: drives a 16:1 mux tree's data/select and samples its output LSB-first into a serial stream and a 16-bit capture
// Ports: clk, rst (synchronous, active-high); start/din begin a scan of din (accepted only when idle);
//   A/S drive the mux tree data/select, w is the tree output; busy is high while scanning;
//   sout/sout_valid carry each sampled bit; dout is the captured word; done pulses after bit 15;
//   mismatch flags capture != A, built only when MUX_SCAN_CHECK_EN is defined (tied 0 otherwise).
// HOLD: cycles each select value is held before sampling (1..15).
module mux_scan_serializer #(
  parameter int HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic [15:0] A,
  output logic [3:0]  S,
  input  logic        w,
  output logic        busy,
  output logic        sout,
  output logic        sout_valid,
  output logic [15:0] dout,
  output logic        done,
  output logic        mismatch
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [3:0] LAST = 4'(HOLD - 1);
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_s;
  logic [15:0] r_a;
  logic [15:0] r_dout;
  logic        r_busy;
  logic        r_sout;
  logic        r_sv;
  logic        r_done;
`ifdef MUX_SCAN_CHECK_EN
  logic        r_mis;
  assign mismatch = r_mis;
`else
  assign mismatch = 1'b0;
`endif
  assign A          = r_a;
  assign S          = r_s;
  assign busy       = r_busy;
  assign sout       = r_sout;
  assign sout_valid = r_sv;
  assign dout       = r_dout;
  assign done       = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= '0;
      r_a     <= '0;
      r_dout  <= '0;
      r_busy  <= 1'b0;
      r_sout  <= 1'b0;
      r_sv    <= 1'b0;
      r_done  <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= SCAN;
          r_a     <= din;
          r_s     <= '0;
          r_cnt   <= '0;
          r_dout  <= '0;
          r_busy  <= 1'b1;
`ifdef MUX_SCAN_CHECK_EN
          r_mis   <= 1'b0;
`endif
        end
        SCAN: if (r_cnt == LAST) begin
          r_dout[r_s] <= w;
          r_sout      <= w;
          r_sv        <= 1'b1;
          r_cnt       <= '0;
          if (r_s == 4'd15) begin
            // select stays at 15; the scan never wraps
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
`ifdef MUX_SCAN_CHECK_EN
            // bit 15 is still in flight, so splice the live sample into the compare
            r_mis   <= {w, r_dout[14:0]} != r_a;
`endif
          end else begin
            r_s <= r_s + 4'd1;
          end
        end else begin
          r_cnt <= r_cnt + 4'd1;
          r_sv  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_sv    <= 1'b0;
        end
      endcase
    end
  end
endmodule
